// File: rtl/pipecleaner_uart_tx_if.sv
// Byte handshake between the tile core and the UART serializer.
// The producer drives in_valid/in_data; the serializer returns in_ready.
interface pipecleaner_uart_tx_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/pipecleaner_uart_tx.sv
// Byte FIFO feeding an 8N1 UART serializer; one output pin, no host handshake.
// tx, in_ready, busy and fifo_level come only from registers or pointer compares.
module pipecleaner_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   pipecleaner_uart_tx_if.slave          in_if,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BaudReload = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BaudOne    = BW'(1);
   localparam logic [AW:0]   PtrOne     = (AW + 1)'(1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic          push, pop, empty, full;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign in_if.in_ready = !full;
   assign push           = in_if.in_valid && !full;
   assign fifo_level     = wr_ptr_q - rd_ptr_q;
   assign busy           = (state_q != StIdle) || !empty;
   assign tx             = tx_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= in_if.in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // tx_d is the level of the bit being entered, so tx_q lines up with state_q.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;

      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q[AW-1:0]];
               baud_d  = BaudReload;
               state_d = StStart;
               tx_d    = 1'b0;
            end
         end
         StStart: begin
            if (baud_q != '0) begin
               baud_d = baud_q - BaudOne;
            end else begin
               baud_d  = BaudReload;
               bit_d   = 3'd0;
               state_d = StData;
               tx_d    = shift_q[0];
            end
         end
         StData: begin
            if (baud_q != '0) begin
               baud_d = baud_q - BaudOne;
            end else begin
               baud_d = BaudReload;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end
         StStop: begin
            if (baud_q != '0) begin
               baud_d = baud_q - BaudOne;
            end else if (!empty) begin
               // Chain straight into the next start bit: no idle gap between frames.
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q[AW-1:0]];
               baud_d  = BaudReload;
               state_d = StStart;
               tx_d    = 1'b0;
            end else begin
               state_d = StIdle;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_pipecleaner_uart_tx.sv
// Bench for pipecleaner_uart_tx: accepted bytes go into a queue, a UART receiver
// model decodes tx frames and pops/compares; directed timing checks around it.
module tb_pipecleaner_uart_tx;
   localparam int CPB = 4;

   logic       clk;
   logic       rst;
   logic       tx0, busy0, tx1, busy1;
   logic [2:0] lvl0;
   logic [1:0] lvl1;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          last_acc = 0;
   logic [7:0]  exp_q[$];
   int          starts[$];

   pipecleaner_uart_tx_if u_if0 ();
   pipecleaner_uart_tx_if u_if1 ();

   pipecleaner_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .in_if      (u_if0.slave),
      .tx         (tx0),
      .busy       (busy0),
      .fifo_level (lvl0)
   );

   pipecleaner_uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(2)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .in_if      (u_if1.slave),
      .tx         (tx1),
      .busy       (busy1),
      .fifo_level (lvl1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tx"}, tx0, 1);
      check({tag, "_ready"}, u_if0.in_ready, 1);
      check({tag, "_busy"}, busy0, 0);
      check({tag, "_level"}, lvl0, 0);
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [7:0] b, input bit keep);
      int n;
      n = 0;
      u_if0.in_valid = 1'b1;
      u_if0.in_data  = b;
      while (!u_if0.in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("send_accept", u_if0.in_ready, 1);
      if (!u_if0.in_ready) begin
         u_if0.in_valid = 1'b0;
         return;
      end
      exp_q.push_back(b);
      last_acc = cyc + 1;
      @(negedge clk);
      if (!keep) begin
         u_if0.in_valid = 1'b0;
         u_if0.in_data  = 8'($urandom);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", n < 3000, 1);
      repeat (2) @(negedge clk);
      check("drain_tx", tx0, 1);
      check("drain_level", lvl0, 0);
   endtask

   // UART receiver model: a frame is 10 bits of CPB cycles, each bit constant.
   initial begin : monitor
      logic [9:0] bits;
      bit         abort, glitch;
      int         st;
      forever begin
         @(negedge clk);
         if (rst || tx0 !== 1'b0) continue;
         st     = cyc;
         abort  = 0;
         glitch = 0;
         bits   = '0;
         for (int i = 0; i < 10 * CPB && !abort; i++) begin
            if (i != 0) @(negedge clk);
            if (rst) begin
               abort = 1;
            end else if (i % CPB == 0) begin
               bits[i / CPB] = tx0;
            end else if (tx0 !== bits[i / CPB]) begin
               glitch = 1;
            end
         end
         if (!abort) begin
            starts.push_back(st);
            check("frame_bit_stable", glitch, 0);
            check("frame_start_bit", bits[0], 0);
            check("frame_stop_bit", bits[9], 1);
            check("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("frame_data", bits[8:1], exp_q.pop_front());
         end
      end
   end

   initial begin : stim
      int         acc_a, t, n, got, acc1, gap;
      logic [7:0] b;
      logic [9:0] frame;
      bit         keep;

      rst = 1'b1;
      u_if0.in_valid = 1'b0;
      u_if0.in_data  = '0;
      u_if1.in_valid = 1'b0;
      u_if1.in_data  = '0;

      // Reset held with random inputs.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         u_if0.in_valid = 1'($urandom_range(0, 1));
         u_if0.in_data  = 8'($urandom);
         u_if1.in_valid = 1'($urandom_range(0, 1));
         u_if1.in_data  = 8'($urandom);
         #1 check_idle("reset_hold");
         check("reset_hold_tx1", tx1, 1);
      end
      @(negedge clk);
      u_if0.in_valid = 1'b0;
      u_if1.in_valid = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset_after");

      // Single byte 0xA5: tx falls one edge after accept; busy drops 40 cycles later.
      starts.delete();
      send(8'hA5, 0);
      n = 0;
      while (starts.size() == 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("a5_frame_seen", starts.size(), 1);
      if (starts.size() != 0) begin
         check("a5_latency", starts[0], last_acc + 1);
         n = 0;
         while (busy0 && n < 100) begin
            @(negedge clk);
            n++;
         end
         check("a5_busy_drop", cyc - starts[0], 40);
      end
      drain();

      // Burst 0x01..0x06 with in_valid held.
      starts.delete();
      for (int i = 1; i <= 5; i++) send(8'(i), 1);
      check("burst_level_full", lvl0, 4);
      check("burst_ready_low", u_if0.in_ready, 0);
      send(8'h06, 0);
      t = last_acc;
      drain();
      check("burst_frames", starts.size(), 6);
      if (starts.size() == 6) begin
         check("burst_stall_release", t, starts[0] + 41);
         for (int k = 1; k < 6; k++) check("burst_contiguous", starts[k] - starts[k-1], 40);
      end

      // Push lands on the exact edge frame A finishes and pops B.
      send(8'hA1, 1);
      acc_a = last_acc;
      send(8'hB2, 1);
      send(8'hC3, 0);
      check("pp_level_before", lvl0, 2);
      while (cyc < acc_a + 40) @(negedge clk);
      send(8'hD4, 0);
      check("pp_accept_edge", last_acc, acc_a + 41);
      check("pp_level_after", lvl0, 2);
      drain();

      // Reset during data bit 3 of 0xFF with two bytes queued.
      send(8'hFF, 1);
      t = last_acc + 1;
      send(8'h11, 1);
      send(8'h22, 0);
      while (cyc < t + 17) @(negedge clk);
      check("mid_tx_before", tx0, 1);
      check("mid_level_before", lvl0, 2);
      #1 rst = 1'b1;
      #1;
      check_idle("mid_reset");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle("mid_release");
      send(8'h00, 0);
      drain();

      // CLKS_PER_BIT=1, FIFO_DEPTH=2: two back-to-back 0x3C frames.
      u_if1.in_valid = 1'b1;
      u_if1.in_data  = 8'h3C;
      got = 0;
      acc1 = 0;
      n = 0;
      while (got < 2 && n < 50) begin
         if (u_if1.in_ready) begin
            if (got == 0) acc1 = cyc + 1;
            got++;
         end
         @(negedge clk);
         n++;
      end
      u_if1.in_valid = 1'b0;
      check("p1_accepts", got, 2);
      n = 0;
      while (tx1 !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("p1_latency", cyc, acc1 + 1);
      b = 8'h3C;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 20; i++) begin
         if (i != 0) @(negedge clk);
         check("p1_bit", tx1, frame[i % 10]);
      end
      @(negedge clk);
      check("p1_idle_tx", tx1, 1);
      check("p1_idle_busy", busy1, 0);
      check("p1_idle_level", lvl1, 0);

      // Randomised traffic against the scoreboard.
      for (int i = 0; i < 24; i++) begin
         b    = 8'($urandom);
         keep = ($urandom_range(0, 2) != 0) && (i < 23);
         send(b, keep);
         check("rand_ready_vs_level", u_if0.in_ready, lvl0 < 3'd4);
         if (!keep) begin
            gap = $urandom_range(0, 50);
            repeat (gap) begin
               @(negedge clk);
               u_if0.in_data = 8'($urandom);
            end
         end
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
